// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and sizes for the boot loader: FSM state encoding and byte/word geometry.
package boot_loader_ctrl_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int LED_CNT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Boot loader bus bundle: UART byte input, load request, imem write port and core/status outputs.
interface boot_loader_ctrl_if #(
  parameter int INST_MEM_WIDTH = 5
);
  import boot_loader_ctrl_pkg::*;

  logic                      i_start;
  logic                      i_rx_valid;
  logic [BYTE_W-1:0]         i_rx_data;
  logic                      o_imem_we;
  logic [INST_MEM_WIDTH-1:0] o_imem_addr;
  logic [WORD_W-1:0]         o_imem_wdata;
  logic                      o_cpu_rst;
  logic                      o_busy;
  logic                      o_err;
  logic [7:0]                o_status;

  modport slave (
    input  i_start, i_rx_valid, i_rx_data,
    output o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_rst, o_busy, o_err, o_status
  );

  modport master (
    output i_start, i_rx_valid, i_rx_data,
    input  o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_rst, o_busy, o_err, o_status
  );

endinterface

// File: rtl/boot_loader_ctrl_byte_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; word_done flags the cycle the 4th byte arrives.
module boot_loader_ctrl_byte_assembler
  import boot_loader_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);

  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [1:0]               r_byte_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      r_shift    <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  // The completed word is presented combinationally so the writer can register it on the same edge.
  assign o_word      = {r_shift, i_byte};
  assign o_word_done = i_accept && (r_byte_cnt == 2'd3);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader sequencer: length header, data words to imem from address 0, then core release.
// Optional trailing XOR checksum byte when BOOT_CHECKSUM_EN is defined.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 5
)(
  input logic               i_clk,
  input logic               i_rst,
  boot_loader_ctrl_if.slave bus
);

  localparam int                CNT_W    = INST_MEM_WIDTH + 1;
  localparam logic [WORD_W-1:0] CAPACITY = WORD_W'(1) << INST_MEM_WIDTH;

  state_e                    r_state;
  state_e                    w_next_state;
  state_e                    w_done_state;
  logic [CNT_W-1:0]          r_word_cnt;
  logic [CNT_W-1:0]          r_len;
  logic                      r_imem_we;
  logic [INST_MEM_WIDTH-1:0] r_imem_addr;
  logic [WORD_W-1:0]         r_imem_wdata;
  logic                      w_collect;
  logic                      w_word_done;
  logic                      w_write;
  logic                      w_last_word;
  logic [WORD_W-1:0]         w_word;
  logic [LED_CNT_W-1:0]      w_words_led;

  // A byte coinciding with start is dropped: start wins and restarts the header.
  assign w_collect   = bus.i_rx_valid && !bus.i_start && (r_state == S_LEN || r_state == S_DATA);
  assign w_write     = w_word_done && (r_state == S_DATA);
  assign w_last_word = (r_word_cnt + CNT_W'(1)) == r_len;

  boot_loader_ctrl_byte_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (bus.i_start),
    .i_accept    (w_collect),
    .i_byte      (bus.i_rx_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
  logic              w_chk_byte;

  assign w_chk_byte   = bus.i_rx_valid && !bus.i_start && (r_state == S_CHK);
  assign w_done_state = S_CHK;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= '0;
    end else if (bus.i_start) begin
      r_csum <= '0;
    end else if (w_collect) begin
      r_csum <= r_csum ^ bus.i_rx_data;
    end
  end
`else
  assign w_done_state = S_RUN;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: holding the current state as the first assignment keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    if (bus.i_start) begin
      w_next_state = S_LEN;
    end else begin
      case (r_state)
        S_IDLE, S_RUN, S_ERR: w_next_state = r_state;
        S_LEN: begin
          if (w_word_done) begin
            if (w_word == '0)           w_next_state = w_done_state;
            else if (w_word > CAPACITY) w_next_state = S_ERR;
            else                        w_next_state = S_DATA;
          end
        end
        S_DATA: begin
          if (w_write && w_last_word) w_next_state = w_done_state;
        end
        S_CHK: begin
`ifdef BOOT_CHECKSUM_EN
          if (w_chk_byte) w_next_state = (bus.i_rx_data == r_csum) ? S_RUN : S_ERR;
`else
          w_next_state = S_ERR;
`endif
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word_cnt   <= '0;
      r_len        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= 1'b0;
      if (bus.i_start) begin
        r_word_cnt <= '0;
        r_len      <= '0;
      end else begin
        if (r_state == S_LEN && w_word_done) r_len <= w_word[CNT_W-1:0];
        // Length was bounded by capacity, so the index never exceeds the top address.
        if (w_write) begin
          r_imem_we    <= 1'b1;
          r_imem_addr  <= r_word_cnt[INST_MEM_WIDTH-1:0];
          r_imem_wdata <= w_word;
          r_word_cnt   <= r_word_cnt + CNT_W'(1);
        end
      end
    end
  end

  generate
    if (CNT_W >= LED_CNT_W) begin : g_led_trunc
      assign w_words_led = r_word_cnt[LED_CNT_W-1:0];
    end else begin : g_led_pad
      assign w_words_led = {{(LED_CNT_W-CNT_W){1'b0}}, r_word_cnt};
    end
  endgenerate

  assign bus.o_imem_we    = r_imem_we;
  assign bus.o_imem_addr  = r_imem_addr;
  assign bus.o_imem_wdata = r_imem_wdata;
  assign bus.o_cpu_rst    = (r_state != S_RUN);
  assign bus.o_busy       = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign bus.o_err        = (r_state == S_ERR);
  assign bus.o_status     = {r_state, w_words_led};

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: streams length/data bytes and checks writes and core release.
module tb_boot_loader_ctrl;

  localparam int W   = 5;
  localparam int CAP = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [W-1:0] wr_addr[$];
  logic [31:0]  wr_data[$];

  always #5 clk = ~clk;

  boot_loader_ctrl_if #(.INST_MEM_WIDTH(W)) bus ();

  boot_loader_ctrl #(.INST_MEM_WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.o_imem_we === 1'b1) begin
      wr_addr.push_back(bus.o_imem_addr);
      wr_data.push_back(bus.o_imem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) repeat ($urandom_range(0, 2)) tick();
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'($urandom);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Reference: a load is a big-endian count followed by that many big-endian words.
  function automatic void make_load(input int n, output logic [7:0] s[$], output logic [31:0] words[$]);
    logic [31:0] nv;
    logic [31:0] w;
    nv = 32'(n);
    s = {};
    words = {};
    for (int k = 3; k >= 0; k--) s.push_back(nv[8*k +: 8]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      words.push_back(w);
      for (int k = 3; k >= 0; k--) s.push_back(w[8*k +: 8]);
    end
  endfunction

  function automatic logic [7:0] xor_all(input logic [7:0] s[$]);
    logic [7:0] r;
    r = 8'h00;
    foreach (s[i]) r ^= s[i];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if (bus.o_cpu_rst !== 1'b1) begin miscompares++; $display("FAIL reset_hold_cpu_rst: got %b expected 1", bus.o_cpu_rst); end
    rst = 1'b0;
    tick();
    vectors++; if (bus.o_cpu_rst !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_rst: got %b expected 1", bus.o_cpu_rst); end
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    vectors++; if (bus.o_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.o_err); end
    vectors++; if (bus.o_imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", bus.o_imem_we); end
    vectors++; if (bus.o_status !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h expected 00", bus.o_status); end
    vectors++; if (bus.o_imem_addr !== '0 || bus.o_imem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_bus: got %h/%h expected 0/0", bus.o_imem_addr, bus.o_imem_wdata); end
    wr_addr = {}; wr_data = {};
    send_stream({8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
    tick();
    vectors++; if (wr_data.size() != 0 || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignores_rx: got %0d writes busy %b expected 0 writes busy 0", wr_data.size(), bus.o_busy); end
  endtask

  task automatic test_basic_load();
    logic [7:0] s[$];
    s = {8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    wr_addr = {}; wr_data = {};
    pulse_start();
    vectors++; if (bus.o_busy !== 1'b1 || bus.o_cpu_rst !== 1'b1) begin miscompares++; $display("FAIL basic_len_entry: got busy %b cpu_rst %b expected 1 1", bus.o_busy, bus.o_cpu_rst); end
    send_stream(s, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL basic_chk_wait: got busy %b expected 1", bus.o_busy); end
    send_byte(xor_all(s), 1'b1);
`endif
    vectors++; if (bus.o_cpu_rst !== 1'b0 || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL basic_release: got cpu_rst %b busy %b expected 0 0", bus.o_cpu_rst, bus.o_busy); end
    tick();
    vectors++; if (wr_data.size() != 2) begin miscompares++; $display("FAIL basic_wr_count: got %0d expected 2", wr_data.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h12345678) begin miscompares++; $display("FAIL basic_wr0: got [%0d]=%h expected [0]=12345678", wr_addr[0], wr_data[0]); end
      vectors++; if (wr_addr[1] !== 5'd1 || wr_data[1] !== 32'h9ABCDEF0) begin miscompares++; $display("FAIL basic_wr1: got [%0d]=%h expected [1]=9abcdef0", wr_addr[1], wr_data[1]); end
    end
    vectors++; if (bus.o_status[4:0] !== 5'd2) begin miscompares++; $display("FAIL basic_status_words: got %0d expected 2", bus.o_status[4:0]); end
  endtask

  task automatic test_len_overflow();
    logic [7:0]  s[$];
    logic [31:0] words[$];
    wr_addr = {}; wr_data = {};
    pulse_start();
    send_stream({8'h00, 8'h00, 8'h00, 8'(CAP + 1)}, 1'b1);
    vectors++; if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_cpu_rst !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got err %b busy %b cpu_rst %b expected 1 0 1", bus.o_err, bus.o_busy, bus.o_cpu_rst); end
    repeat (8) send_byte(8'($urandom), 1'b1);
    tick();
    vectors++; if (wr_data.size() != 0 || bus.o_err !== 1'b1) begin miscompares++; $display("FAIL ovf_hold: got %0d writes err %b expected 0 writes err 1", wr_data.size(), bus.o_err); end
    pulse_start();
    vectors++; if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL ovf_recover: got err %b busy %b expected 0 1", bus.o_err, bus.o_busy); end
    // Exactly full capacity is legal and fills every address.
    make_load(CAP, s, words);
    send_stream(s, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(xor_all(s), 1'b0);
`endif
    vectors++; if (bus.o_cpu_rst !== 1'b0 || bus.o_err !== 1'b0) begin miscompares++; $display("FAIL cap_release: got cpu_rst %b err %b expected 0 0", bus.o_cpu_rst, bus.o_err); end
    tick();
    vectors++;
    if (wr_data.size() != CAP) begin miscompares++; $display("FAIL cap_wr_count: got %0d expected %0d", wr_data.size(), CAP); end
    else begin
      foreach (words[i]) begin
        vectors++;
        if (wr_addr[i] !== W'(i) || wr_data[i] !== words[i]) begin miscompares++; $display("FAIL cap_wr%0d: got [%0d]=%h expected [%0d]=%h", i, wr_addr[i], wr_data[i], i, words[i]); end
      end
    end
    vectors++; if (bus.o_status[4:0] !== 5'(CAP)) begin miscompares++; $display("FAIL cap_status_words: got %0d expected %0d", bus.o_status[4:0], 5'(CAP)); end
  endtask

  task automatic test_zero_length();
    wr_addr = {}; wr_data = {};
    pulse_start();
    send_stream({8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    vectors++; if (bus.o_busy !== 1'b1 || bus.o_cpu_rst !== 1'b1) begin miscompares++; $display("FAIL zero_chk_wait: got busy %b cpu_rst %b expected 1 1", bus.o_busy, bus.o_cpu_rst); end
    send_byte(8'h00, 1'b1);
`endif
    vectors++; if (bus.o_cpu_rst !== 1'b0 || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL zero_release: got cpu_rst %b busy %b expected 0 0", bus.o_cpu_rst, bus.o_busy); end
    tick();
    vectors++; if (wr_data.size() != 0) begin miscompares++; $display("FAIL zero_writes: got %0d expected 0", wr_data.size()); end
  endtask

  task automatic test_restart();
    logic [7:0] s[$];
    s = {8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    wr_addr = {}; wr_data = {};
    pulse_start();
    send_stream({8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB}, 1'b1);
    // Restart with a byte on the same cycle: that byte must not reach the new header.
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'hFF;
    pulse_start();
    bus.i_rx_valid = 1'b0;
    send_stream(s, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    send_byte(xor_all(s), 1'b1);
`endif
    vectors++; if (bus.o_cpu_rst !== 1'b0 || bus.o_err !== 1'b0) begin miscompares++; $display("FAIL restart_release: got cpu_rst %b err %b expected 0 0", bus.o_cpu_rst, bus.o_err); end
    tick();
    vectors++; if (wr_data.size() != 1) begin miscompares++; $display("FAIL restart_wr_count: got %0d expected 1", wr_data.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h11223344) begin miscompares++; $display("FAIL restart_wr0: got [%0d]=%h expected [0]=11223344", wr_addr[0], wr_data[0]); end
    end
  endtask

  task automatic test_random_loads();
    logic [7:0]  s[$];
    logic [31:0] words[$];
    int          n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      make_load(n, s, words);
      wr_addr = {}; wr_data = {};
      pulse_start();
      send_stream(s, 1'b1);
`ifdef BOOT_CHECKSUM_EN
      send_byte(xor_all(s), 1'b1);
`endif
      vectors++; if (bus.o_cpu_rst !== 1'b0) begin miscompares++; $display("FAIL rand%0d_release: got cpu_rst %b expected 0", it, bus.o_cpu_rst); end
      repeat (3) send_byte(8'($urandom), 1'b1);
      tick();
      vectors++;
      if (wr_data.size() != n) begin miscompares++; $display("FAIL rand%0d_wr_count: got %0d expected %0d", it, wr_data.size(), n); end
      else begin
        foreach (words[i]) begin
          vectors++;
          if (wr_addr[i] !== W'(i) || wr_data[i] !== words[i]) begin miscompares++; $display("FAIL rand%0d_wr%0d: got [%0d]=%h expected [%0d]=%h", it, i, wr_addr[i], wr_data[i], i, words[i]); end
        end
      end
      vectors++; if (bus.o_cpu_rst !== 1'b0 || bus.o_status[4:0] !== 5'(n)) begin miscompares++; $display("FAIL rand%0d_run_hold: got cpu_rst %b words %0d expected 0 %0d", it, bus.o_cpu_rst, bus.o_status[4:0], n); end
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum_bad();
    logic [7:0] s[$];
    s = {8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    pulse_start();
    send_stream(s, 1'b1);
    send_byte(xor_all(s) ^ 8'h01, 1'b1);
    vectors++; if (bus.o_err !== 1'b1 || bus.o_cpu_rst !== 1'b1) begin miscompares++; $display("FAIL chk_bad: got err %b cpu_rst %b expected 1 1", bus.o_err, bus.o_cpu_rst); end
  endtask
`endif

  task automatic test_reset_mid_data();
    wr_addr = {}; wr_data = {};
    pulse_start();
    send_stream({8'h00, 8'h00, 8'h00, 8'h04, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02}, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.o_busy !== 1'b0 || bus.o_cpu_rst !== 1'b1 || bus.o_status !== 8'h00) begin miscompares++; $display("FAIL rst_async: got busy %b cpu_rst %b status %h expected 0 1 00", bus.o_busy, bus.o_cpu_rst, bus.o_status); end
    tick();
    rst = 1'b0;
    send_stream({8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A}, 1'b1);
    tick();
    vectors++; if (wr_data.size() != 1 || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_ignore: got %0d writes busy %b expected 1 writes busy 0", wr_data.size(), bus.o_busy); end
    else begin
      vectors++; if (wr_data[0] !== 32'hCAFEBABE) begin miscompares++; $display("FAIL rst_pre_write: got %h expected cafebabe", wr_data[0]); end
    end
    pulse_start();
    vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL rst_restart: got busy %b expected 1", bus.o_busy); end
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    test_reset();
    test_basic_load();
    test_len_overflow();
    test_zero_length();
    test_restart();
    test_random_loads();
`ifdef BOOT_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
